// File: rtl/avr_io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : avr_io_pkg
// Purpose : Shared register offsets, STATUS bit positions and transmitter
//           FSM states for avr_cpu memory-mapped I/O peripherals.
// Revision: 1.0
// ============================================================================
package avr_io_pkg;

    localparam logic [1:0] C_OFF_DATA   = 2'd0;
    localparam logic [1:0] C_OFF_STATUS = 2'd1;
    localparam logic [1:0] C_OFF_DIV_LO = 2'd2;
    localparam logic [1:0] C_OFF_DIV_HI = 2'd3;

    localparam int C_ST_EMPTY = 0;
    localparam int C_ST_FULL  = 1;
    localparam int C_ST_BUSY  = 2;
    localparam int C_ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/avr_fifo.sv
`default_nettype none
// ============================================================================
// Module  : avr_fifo
// Purpose : Parameterised synchronous FIFO with show-ahead read data.
// Revision: 1.0
// ============================================================================
module avr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    wire w_do_push = i_push && !o_full;
    wire w_do_pop  = i_pop  && !o_empty;

    assign o_full  = (r_count == C_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/avr_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : avr_uart_tx
// Purpose : Memory-mapped 8N1 UART transmitter slave on the avr_cpu data bus.
// Revision: 1.0
// ============================================================================
module avr_uart_tx
    import avr_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h00C0,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd415
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_addr,
    input  logic        data_wen,
    input  logic        data_ren,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic        hit,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] C_FULL_CNT = CW'(FIFO_DEPTH);

    logic [15:0]  r_div;
    logic [15:0]  r_div_act;
    logic         r_ovf;
    logic [7:0]   r_rdata;
    logic         r_hit;
    tx_state_t    r_state;
    logic         r_tx;
    logic [15:0]  r_baud;
    logic [7:0]   r_shift;
    logic [2:0]   r_bitcnt;

    logic [7:0]   w_fifo_data;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [7:0]   w_rd_mux;

    wire       w_in_win  = (data_addr[15:2] == BASE_ADDR[15:2]);
    wire [1:0] w_off     = data_addr[1:0];
    wire       w_wr_data = data_wen && w_in_win && (w_off == C_OFF_DATA);
    wire       w_has_room = (w_fifo_count != C_FULL_CNT);
    wire       w_push    = w_wr_data && w_has_room;
    wire       w_ovf_set = w_wr_data && !w_has_room;
    wire       w_rd      = data_ren && w_in_win;
    wire       w_busy    = (r_state != S_IDLE);
    wire       w_bit_end = (r_baud == r_div_act);
    wire       w_pop     = !w_fifo_empty &&
                           ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    wire [7:0] w_status = {4'b0000, r_ovf, w_busy, w_fifo_full, w_fifo_empty};

    avr_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (data_write),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_off)
            C_OFF_STATUS: w_rd_mux = w_status;
            C_OFF_DIV_LO: w_rd_mux = r_div[7:0];
            C_OFF_DIV_HI: w_rd_mux = r_div[15:8];
            default:      w_rd_mux = 8'h00;
        endcase
    end

    // An overflowing write outranks the read-to-clear of OVF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= DIV_RESET;
            r_ovf   <= 1'b0;
            r_rdata <= 8'h00;
            r_hit   <= 1'b0;
        end else begin
            r_hit   <= w_rd;
            r_rdata <= w_rd ? w_rd_mux : 8'h00;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_rd && (w_off == C_OFF_STATUS)) begin
                r_ovf <= 1'b0;
            end
            if (data_wen && w_in_win && (w_off == C_OFF_DIV_LO)) begin
                r_div[7:0] <= data_write;
            end
            if (data_wen && w_in_win && (w_off == C_OFF_DIV_HI)) begin
                r_div[15:8] <= data_write;
            end
        end
    end

    // r_div_act is sampled only at bit boundaries so a bit in flight keeps its length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_baud    <= 16'd0;
            r_div_act <= DIV_RESET;
            r_shift   <= 8'h00;
            r_bitcnt  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_fifo_data;
                        r_div_act <= r_div;
                        r_baud    <= 16'd0;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud    <= 16'd0;
                        r_div_act <= r_div;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bitcnt  <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud    <= 16'd0;
                        r_div_act <= r_div;
                        if (r_bitcnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud    <= 16'd0;
                        r_div_act <= r_div;
                        if (w_pop) begin
                            r_shift <= w_fifo_data;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign data_read = r_rdata;
    assign hit       = r_hit;
    assign tx        = r_tx;

endmodule
`default_nettype wire
